// File: rtl/game_state_fsm.sv
// game_state_fsm: frame-rate game controller.
// Sequences a run through IDLE, RUN, DYING and WON from the start key and the
// obstacles' collision flags, and keeps the BCD score, best score and attempt
// count shown on the HUD.
module game_state_fsm #(
  parameter int          NUM_OBST     = 4,
  parameter int          DEATH_FRAMES = 60,
  parameter logic [15:0] WIN_SCORE    = 16'h0500
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                start_key,
  input  logic [NUM_OBST-1:0] collide_vec,
  output logic                start_moving,
  output logic                obstacle_reset,
  output logic                flash,
  output logic [1:0]          game_state,
  output logic [15:0]         score,
  output logic [15:0]         best_score,
  output logic [7:0]          attempts
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DYING = 2'd2,
    WON   = 2'd3
  } state_t;

  // The counter is loaded with DEATH_FRAMES-1 so that DYING lasts exactly
  // DEATH_FRAMES frames, including the frame on which it reaches zero.
  localparam logic [7:0] DEATH_LOAD = 8'(DEATH_FRAMES - 1);

  state_t      state, state_next;
  logic        key_prev;
  logic        key_edge;
  logic        any_collide;
  logic [7:0]  death_cnt, death_cnt_next;
  logic [15:0] score_next, best_next, score_inc;
  logic [7:0]  attempts_next, attempts_inc;

  // Four-digit BCD increment with digit carry; holds at 9999.
  function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] >= 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Two-digit BCD increment; holds at 99.
  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v != 8'h99) begin
      if (v[3:0] >= 4'd9) begin
        r[3:0] = 4'd0;
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[3:0] = v[3:0] + 4'd1;
      end
    end
    return r;
  endfunction

  assign key_edge     = start_key & ~key_prev;
  assign any_collide  = |collide_vec;
  assign score_inc    = bcd_inc16(score);
  assign attempts_inc = bcd_inc8(attempts);

  // State, counters and key history advance once per frame.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      key_prev   <= 1'b1;
      death_cnt  <= 8'd0;
      score      <= 16'h0000;
      best_score <= 16'h0000;
      attempts   <= 8'h00;
    end else begin
      state      <= state_next;
      key_prev   <= start_key;
      death_cnt  <= death_cnt_next;
      score      <= score_next;
      best_score <= best_next;
      attempts   <= attempts_next;
    end
  end

  // Next-state and datapath updates; collision takes priority over winning.
  always_comb begin
    state_next     = state;
    death_cnt_next = death_cnt;
    score_next     = score;
    best_next      = best_score;
    attempts_next  = attempts;
    case (state)
      IDLE: begin
        if (key_edge) begin
          state_next    = RUN;
          score_next    = 16'h0000;
          attempts_next = attempts_inc;
        end
      end
      RUN: begin
        if (any_collide) begin
          state_next     = DYING;
          death_cnt_next = DEATH_LOAD;
          if (score > best_score) best_next = score;
        end else if (score_inc == WIN_SCORE) begin
          state_next = WON;
          score_next = WIN_SCORE;
          if (WIN_SCORE > best_score) best_next = WIN_SCORE;
        end else begin
          score_next = score_inc;
        end
      end
      DYING: begin
        if (death_cnt == 8'd0) state_next = IDLE;
        else death_cnt_next = death_cnt - 8'd1;
      end
      WON: begin
        if (key_edge) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode the registered state only.
  always_comb begin
    start_moving   = (state == RUN);
    obstacle_reset = (state != RUN);
    game_state     = state;
    flash          = (state == DYING) & death_cnt[3];
  end

endmodule

// File: tb/tb_game_state_fsm.sv
// tb_game_state_fsm: directed bench with a decimal-arithmetic reference model
// compared every frame, plus hand-computed literal checkpoints.
module tb_game_state_fsm;

  localparam int          NUM_OBST     = 4;
  localparam int          DEATH_FRAMES = 60;
  localparam logic [15:0] WIN_SCORE    = 16'h0500;
  localparam int          WIN_DEC      = 500;

  logic                frame_clk = 1'b0;
  logic                Reset;
  logic                start_key;
  logic [NUM_OBST-1:0] collide_vec;
  logic                start_moving, obstacle_reset, flash;
  logic [1:0]          game_state;
  logic [15:0]         score, best_score;
  logic [7:0]          attempts;

  int total = 0;
  int bad   = 0;

  game_state_fsm #(
    .NUM_OBST(NUM_OBST),
    .DEATH_FRAMES(DEATH_FRAMES),
    .WIN_SCORE(WIN_SCORE)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .start_key(start_key),
    .collide_vec(collide_vec),
    .start_moving(start_moving),
    .obstacle_reset(obstacle_reset),
    .flash(flash),
    .game_state(game_state),
    .score(score),
    .best_score(best_score),
    .attempts(attempts)
  );

  // Frame clock: rising edges at 5, 15, 25 ...
  always #5 frame_clk = ~frame_clk;

  // Decimal integer to packed BCD.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge and hold them for the given frames.
  task automatic applyStimulus(input logic key, input logic [NUM_OBST-1:0] coll, input int frames);
    start_key   = key;
    collide_vec = coll;
    repeat (frames) @(negedge frame_clk);
  endtask

  // Reference model in decimal terms; stepped and compared 1 ns after each rising edge.
  int m_state = 0, m_score = 0, m_best = 0, m_att = 0, m_die_start = 0, cycle = 0;
  bit m_kp = 1'b1;

  initial begin
    logic                kv, rs, kedge;
    logic [NUM_OBST-1:0] cv;
    int                  remain;
    logic                m_flash;
    forever begin
      @(posedge frame_clk);
      kv = start_key;
      cv = collide_vec;
      rs = Reset;
      #1;
      cycle++;
      if (rs) begin
        m_state = 0; m_score = 0; m_best = 0; m_att = 0; m_kp = 1'b1;
      end else begin
        kedge = kv && !m_kp;
        m_kp  = kv;
        case (m_state)
          0: if (kedge) begin
               m_state = 1;
               m_score = 0;
               m_att   = (m_att < 99) ? m_att + 1 : 99;
             end
          1: if (cv != 0) begin
               m_state     = 2;
               m_best      = (m_score > m_best) ? m_score : m_best;
               m_die_start = cycle;
             end else if (m_score + 1 == WIN_DEC) begin
               m_state = 3;
               m_score = WIN_DEC;
               m_best  = (WIN_DEC > m_best) ? WIN_DEC : m_best;
             end else if (m_score < 9999) begin
               m_score = m_score + 1;
             end
          2: if (cycle - m_die_start == DEATH_FRAMES) m_state = 0;
          default: if (kedge) m_state = 0;
        endcase
      end
      m_flash = 1'b0;
      if (m_state == 2) begin
        remain  = DEATH_FRAMES - 1 - (cycle - m_die_start);
        m_flash = ((remain / 8) % 2) == 1;
      end
      checkOutput("model game_state", 16'(game_state), 16'(m_state));
      checkOutput("model start_moving", 16'(start_moving), 16'(m_state == 1));
      checkOutput("model obstacle_reset", 16'(obstacle_reset), 16'(m_state != 1));
      checkOutput("model flash", 16'(flash), 16'(m_flash));
      checkOutput("model score", score, to_bcd(m_score));
      checkOutput("model best_score", best_score, to_bcd(m_best));
      checkOutput("model attempts", 16'(attempts), 16'(to_bcd(m_att)));
    end
  end

  // Directed scenario with literal checkpoints.
  initial begin
    Reset       = 1'b1;
    start_key   = 1'b1;
    collide_vec = '0;
    repeat (5) @(negedge frame_clk);
    checkOutput("reset state", 16'(game_state), 16'h0);
    checkOutput("reset obstacle_reset", 16'(obstacle_reset), 16'h1);
    checkOutput("reset score", score, 16'h0000);
    checkOutput("reset attempts", 16'(attempts), 16'h00);
    Reset = 1'b0;
    applyStimulus(1'b1, '0, 2);
    checkOutput("held key no start", 16'(game_state), 16'h0);
    applyStimulus(1'b0, '0, 1);
    applyStimulus(1'b1, '0, 1);
    checkOutput("start state", 16'(game_state), 16'h1);
    checkOutput("start attempts", 16'(attempts), 16'h01);
    checkOutput("start start_moving", 16'(start_moving), 16'h1);
    applyStimulus(1'b0, '0, 10);
    checkOutput("score 10", score, 16'h0010);
    applyStimulus(1'b0, '0, 100);
    checkOutput("score 110", score, 16'h0110);

    // Asynchronous reset in the middle of a run.
    #2 Reset = 1'b1;
    #1;
    checkOutput("midrun reset state", 16'(game_state), 16'h0);
    checkOutput("midrun reset score", score, 16'h0000);
    checkOutput("midrun reset attempts", 16'(attempts), 16'h00);
    @(negedge frame_clk);
    Reset = 1'b0;

    // Run dies at 42.
    applyStimulus(1'b0, '0, 1);
    applyStimulus(1'b1, '0, 1);
    applyStimulus(1'b0, '0, 42);
    checkOutput("score 42", score, 16'h0042);
    applyStimulus(1'b0, 4'b0100, 1);
    checkOutput("collide state", 16'(game_state), 16'h2);
    checkOutput("collide best", best_score, 16'h0042);
    checkOutput("collide score held", score, 16'h0042);
    checkOutput("collide flash first", 16'(flash), 16'h1);
    checkOutput("collide obstacle_reset", 16'(obstacle_reset), 16'h1);
    applyStimulus(1'b0, '0, 4);
    checkOutput("flash low", 16'(flash), 16'h0);
    for (int i = 0; i < 55; i++) applyStimulus(logic'(i % 2), 4'b0001, 1);
    checkOutput("dying last frame", 16'(game_state), 16'h2);
    applyStimulus(1'b0, '0, 1);
    checkOutput("dying to idle", 16'(game_state), 16'h0);
    applyStimulus(1'b1, '0, 1);
    checkOutput("restart first idle", 16'(game_state), 16'h1);
    checkOutput("restart attempts", 16'(attempts), 16'h02);

    // Lower score does not replace best.
    applyStimulus(1'b0, '0, 30);
    checkOutput("score 30", score, 16'h0030);
    applyStimulus(1'b0, 4'b0001, 1);
    checkOutput("lower best kept", best_score, 16'h0042);
    applyStimulus(1'b0, '0, 60);
    checkOutput("idle after 30", 16'(game_state), 16'h0);

    // Collision on the would-be winning frame.
    applyStimulus(1'b1, '0, 1);
    applyStimulus(1'b0, '0, 499);
    checkOutput("score 499", score, 16'h0499);
    applyStimulus(1'b0, 4'b1000, 1);
    checkOutput("collide beats win", 16'(game_state), 16'h2);
    checkOutput("collide beats win score", score, 16'h0499);
    applyStimulus(1'b0, '0, 60);

    // Clean win.
    applyStimulus(1'b1, '0, 1);
    applyStimulus(1'b0, '0, 500);
    checkOutput("won state", 16'(game_state), 16'h3);
    checkOutput("won score", score, 16'h0500);
    checkOutput("won best", best_score, 16'h0500);
    applyStimulus(1'b0, 4'b1111, 3);
    checkOutput("won ignores collide", 16'(game_state), 16'h3);
    applyStimulus(1'b1, '0, 1);
    checkOutput("won to idle", 16'(game_state), 16'h0);

    // Reset while DYING.
    applyStimulus(1'b0, '0, 1);
    applyStimulus(1'b1, '0, 1);
    checkOutput("run6 attempts", 16'(attempts), 16'h05);
    applyStimulus(1'b0, '0, 5);
    applyStimulus(1'b0, 4'b0010, 1);
    applyStimulus(1'b0, '0, 2);
    checkOutput("pre-reset flash", 16'(flash), 16'h1);
    #2 Reset = 1'b1;
    #1;
    checkOutput("dying reset state", 16'(game_state), 16'h0);
    checkOutput("dying reset flash", 16'(flash), 16'h0);
    checkOutput("dying reset score", score, 16'h0000);
    checkOutput("dying reset best", best_score, 16'h0000);
    checkOutput("dying reset attempts", 16'(attempts), 16'h00);
    @(negedge frame_clk);
    Reset = 1'b0;
    applyStimulus(1'b0, '0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_state_fsm.md
# game_state_fsm

Frame-rate game controller that sits directly downstream of the obstacle blocks. It consumes their `will_collide` flags and the start key, and sequences the run through IDLE, RUN, DYING and WON. It drives the obstacles' `start_moving` and reset lines, and keeps the BCD score, best score and attempt count for the HUD. All state advances once per frame.

## Interface

**Parameters**
- `NUM_OBST`, 4: number of obstacle instances whose `will_collide` flags are monitored.
- `DEATH_FRAMES`, 60: number of frames spent in DYING, range 1..255.
- `WIN_SCORE`, 16'h0500: packed 4-digit BCD score at which the run is won.

**Ports** (clock and reset first)
- `frame_clk`, input, 1: frame clock; all state advances on its rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `start_key`, input, 1: start/jump key level, synchronous to `frame_clk`.
- `collide_vec`, input, NUM_OBST: concatenated `will_collide` outputs from the obstacles.
- `start_moving`, output, 1: high only in RUN.
- `obstacle_reset`, output, 1: high in IDLE, DYING and WON; holds obstacles at their spawn X.
- `flash`, output, 1: player blink enable during DYING.
- `game_state`, output, 2: state code; IDLE=0, RUN=1, DYING=2, WON=3.
- `score`, output, 16: current score, packed BCD.
- `best_score`, output, 16: best score, packed BCD.
- `attempts`, output, 8: attempt count, packed BCD, saturates at 8'h99.

## Operation

**Key edge**
- `key_prev` resets to 1, so a key already held at reset does not start a run.
- `key_edge = start_key & ~key_prev`.

**State transitions**
- IDLE -> RUN on `key_edge`. On that edge: `score` <= 0; `attempts` += 1 in BCD, saturating at 99.
- RUN -> DYING when `|collide_vec` is high at the edge. On that edge:
  - `score` is not incremented;
  - `best_score` <= `score` if `score > best_score`;
  - death counter <= DEATH_FRAMES-1.
- RUN -> WON when there is no collision and `score + 1 == WIN_SCORE`. `score` takes the WIN_SCORE value; `best_score` updates by the same rule.
- RUN, otherwise: `score` += 1 in BCD with digit carry, saturating at 16'h9999.
- DYING: counter decrements each frame. When the counter is 0, go to IDLE. `key_edge` is ignored.
- WON -> IDLE on `key_edge`.
- Simultaneous collision and win-score: collision wins; go to DYING.

**Arithmetic and outputs**
- BCD comparison is a plain 16-bit unsigned compare; packed BCD preserves ordering.
- No digit may ever exceed 9.
- `flash` = bit 3 of the death counter while in DYING, else 0.
- `start_moving`, `obstacle_reset` and `game_state` are combinational decodes of the state register only. They do not depend on inputs.

## Timing

- **Reset values:** state = IDLE, so `game_state` = 0, `obstacle_reset` = 1, `start_moving` = 0. `flash` = 0; `score`, `best_score` and `attempts` = 0; `key_prev` = 1; death counter = 0.
- **Reset mid-run:** any state returns to IDLE immediately (asynchronous). `best_score` is cleared too.
- **Key-to-motion latency:** `key_edge` sampled at edge N gives `start_moving` high from edge N onward. Obstacles move from edge N+1.
- **Collision latency:** collision sampled at edge N gives `start_moving` low and `obstacle_reset` high after edge N.
- **DYING duration:** exactly DEATH_FRAMES frames, then IDLE. A key edge on the first IDLE frame starts a new run.
- **Input timing:** `collide_vec` is sampled only in RUN and is ignored elsewhere.

## Test plan

- **Reset and held key:** assert `Reset` with `start_key` held at 1 for 5 frames. Expect state stays IDLE, `obstacle_reset` = 1, all counters 0. Release, then press: RUN on that edge, `attempts` = 8'h01.
- **Score carry:** run 10 frames, then 100 frames. Expect `score` = 16'h0010, then 16'h0110; no illegal digit at any point.
- **Collision:** collide at score 16'h0042. Expect DYING next frame, `best_score` = 16'h0042, `score` held at 42. `flash` toggles every 8 frames. IDLE after exactly 60 frames; key presses during DYING do nothing.
- **Lower score:** second run dies at 16'h0030. Expect `best_score` stays 16'h0042 and `attempts` = 8'h02.
- **Win with simultaneous collision:** set `WIN_SCORE` = 16'h0020. A collision on the frame where score would reach 20 gives DYING. A clean run gives WON with `score` = 16'h0020; a key edge then returns to IDLE.
- **Mid-DYING reset:** assert `Reset` during DYING. Expect IDLE immediately; `flash`, `score`, `best_score` and `attempts` all 0.
